// File: rtl/alu_result_queue.sv
// alu_result_queue
// In-order result buffer between a functional unit and the common data
// buses. Completed results are queued, the queue requests the CDBs while it
// holds anything, and every bus whose select matches ADDRESS in a cycle
// carries the next result in order (lowest granted bus gets the oldest).
// A flush discards everything buffered, including a result offered in the
// flush cycle.

module alu_result_queue #(
    parameter int              XLEN      = 32,
    parameter int              RRN_WIDTH = 6,
    parameter int              DEPTH     = 4,
    parameter int              NUM_CDB   = 2,
    parameter logic [7:0]      ADDRESS   = 8'h00
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,

    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [XLEN-1:0]                in_data,
    input  logic [RRN_WIDTH-1:0]           in_rrn,

    input  logic [NUM_CDB*8-1:0]           cdb_select,
    output logic                           cdb_request,
    output logic [NUM_CDB-1:0]             cdb_valid,
    output logic [NUM_CDB*XLEN-1:0]        cdb_data,
    output logic [NUM_CDB*RRN_WIDTH-1:0]   cdb_rrn,

    output logic [$clog2(DEPTH):0]         count,
    output logic                           full,
    output logic                           empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]      data_mem [DEPTH];
    logic [RRN_WIDTH-1:0] rrn_mem  [DEPTH];

    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [NUM_CDB-1:0]   bus_grant;
    logic [CNT_W-1:0]     pop_cnt;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 push;

    // Status flags come only from the registered occupancy, so a pop in the
    // same cycle never opens a slot for the producer.
    always_comb begin
        full        = (count == CNT_W'(DEPTH));
        empty       = (count == '0);
        in_ready    = !full;
        push        = in_valid && in_ready;
        cdb_request = !empty && !flush;
    end

    // A bus is granted to this unit when its select lane carries ADDRESS.
    always_comb begin
        bus_grant = '0;
        for (int i = 0; i < NUM_CDB; i++) begin
            bus_grant[i] = (cdb_select[i*8 +: 8] == ADDRESS);
        end
    end

    // Walk the buses in ascending order; each granted bus takes the next
    // entry from head until the queue runs out. Flush and reset suppress
    // all broadcasts because those entries are about to vanish.
    always_comb begin
        cdb_valid = '0;
        cdb_data  = '0;
        cdb_rrn   = '0;
        pop_cnt   = '0;
        rd_ptr    = head;
        for (int i = 0; i < NUM_CDB; i++) begin
            if (bus_grant[i] && (pop_cnt < count) && !flush && !reset) begin
                rd_ptr                              = head + pop_cnt[PTR_W-1:0];
                cdb_valid[i]                        = 1'b1;
                cdb_data[i*XLEN +: XLEN]            = data_mem[rd_ptr];
                cdb_rrn[i*RRN_WIDTH +: RRN_WIDTH]   = rrn_mem[rd_ptr];
                pop_cnt                             = pop_cnt + CNT_W'(1);
            end
        end
    end

    // Entry storage; written at tail on an accepted push.
    always_ff @(posedge clock) begin
        if (!reset && !flush && push) begin
            data_mem[tail] <= in_data;
            rrn_mem[tail]  <= in_rrn;
        end
    end

    // Pointer and occupancy update: reset and flush both empty the queue,
    // otherwise push and multi-pop apply together.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            head  <= head + pop_cnt[PTR_W-1:0];
            count <= count + CNT_W'(push) - pop_cnt;
        end
    end

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue with default parameters
// (XLEN=32, RRN_WIDTH=6, DEPTH=4, NUM_CDB=2, ADDRESS=8'h00).

module tb_alu_result_queue;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [5:0]  in_rrn;
    logic [15:0] cdb_select;
    logic        cdb_request;
    logic [1:0]  cdb_valid;
    logic [63:0] cdb_data;
    logic [11:0] cdb_rrn;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int total = 0;
    int bad   = 0;

    alu_result_queue #(
        .XLEN(32), .RRN_WIDTH(6), .DEPTH(4), .NUM_CDB(2), .ADDRESS(8'h00)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rrn(in_rrn),
        .cdb_select(cdb_select), .cdb_request(cdb_request), .cdb_valid(cdb_valid),
        .cdb_data(cdb_data), .cdb_rrn(cdb_rrn),
        .count(count), .full(full), .empty(empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit
    // after that, well clear of the next edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; cdb_select = 16'h1111;
        step();
        reset = 1'b0;
    endtask

    task automatic push_one(input logic [5:0] rrn);
        in_valid = 1'b1; in_rrn = rrn; in_data = 32'h0000_0100 + 32'(rrn);
        cdb_select = 16'h1111;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_rrn = '0;
        cdb_select = 16'h0000;
        step(); step();
        reset = 1'b0;
        settle();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (cdb_request !== 1'b0) begin bad++; $display("FAIL reset_request got=%b exp=0", cdb_request); end
        total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b exp=00", cdb_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (cdb_data !== 64'h0 || cdb_rrn !== 12'h0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0/0", cdb_data, cdb_rrn); end
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_rrn = 6'd5; cdb_select = 16'h0000;
        settle();
        total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL single_no_bypass got=%b exp=00", cdb_valid); end
        step();
        in_valid = 1'b0; cdb_select = {8'h07, 8'h00};
        settle();
        total++; if (cdb_request !== 1'b1) begin bad++; $display("FAIL single_request got=%b exp=1", cdb_request); end
        total++; if (cdb_valid !== 2'b01) begin bad++; $display("FAIL single_valid got=%b exp=01", cdb_valid); end
        total++; if (cdb_data[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_data got=%h exp=deadbeef", cdb_data[31:0]); end
        total++; if (cdb_rrn[5:0] !== 6'd5) begin bad++; $display("FAIL single_rrn got=%0d exp=5", cdb_rrn[5:0]); end
        total++; if (cdb_data[63:32] !== 32'h0 || cdb_rrn[11:6] !== 6'd0) begin bad++; $display("FAIL single_bus1_zero got=%h/%0d exp=0/0", cdb_data[63:32], cdb_rrn[11:6]); end
        step();
        cdb_select = 16'h1111;
        settle();
        total++; if (empty !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL single_drained got=empty%b/count%0d exp=1/0", empty, count); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int r = 1; r <= 4; r++) push_one(6'(r));
        for (int r = 1; r <= 3; r++) begin
            cdb_select = {8'h11, 8'h00};
            settle();
            total++; if (cdb_valid !== 2'b01 || cdb_rrn[5:0] !== 6'(r)) begin bad++; $display("FAIL wrap_pop%0d got=%b/%0d exp=01/%0d", r, cdb_valid, cdb_rrn[5:0], r); end
            step();
        end
        push_one(6'd5);
        push_one(6'd6);
        cdb_select = 16'h0000;
        settle();
        total++; if (cdb_valid !== 2'b11) begin bad++; $display("FAIL wrap_dual_valid got=%b exp=11", cdb_valid); end
        total++; if (cdb_rrn[5:0] !== 6'd4 || cdb_data[31:0] !== 32'h104) begin bad++; $display("FAIL wrap_bus0 got=%0d/%h exp=4/104", cdb_rrn[5:0], cdb_data[31:0]); end
        total++; if (cdb_rrn[11:6] !== 6'd5 || cdb_data[63:32] !== 32'h105) begin bad++; $display("FAIL wrap_bus1 got=%0d/%h exp=5/105", cdb_rrn[11:6], cdb_data[63:32]); end
        step();
        settle();
        total++; if (count !== 3'd1) begin bad++; $display("FAIL wrap_count got=%0d exp=1", count); end
        total++; if (cdb_valid !== 2'b01 || cdb_rrn[5:0] !== 6'd6) begin bad++; $display("FAIL wrap_last got=%b/%0d exp=01/6", cdb_valid, cdb_rrn[5:0]); end
        step();
        cdb_select = 16'h1111;
        settle();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
    endtask

    task automatic test_full();
        do_reset();
        for (int r = 1; r <= 4; r++) push_one(6'(r));
        total++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin bad++; $display("FAIL full_flags got=full%b/rdy%b/count%0d exp=1/0/4", full, in_ready, count); end
        in_valid = 1'b1; in_rrn = 6'd9; in_data = 32'h0000_0109; cdb_select = 16'h1111;
        step();
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_blocked_count got=%0d exp=4", count); end
        cdb_select = {8'h11, 8'h00};
        settle();
        total++; if (cdb_valid !== 2'b01 || cdb_rrn[5:0] !== 6'd1 || in_ready !== 1'b0) begin bad++; $display("FAIL full_pop got=%b/%0d/rdy%b exp=01/1/0", cdb_valid, cdb_rrn[5:0], in_ready); end
        step();
        cdb_select = 16'h1111;
        settle();
        total++; if (count !== 3'd3 || in_ready !== 1'b1) begin bad++; $display("FAIL full_freed got=count%0d/rdy%b exp=3/1", count, in_ready); end
        step();
        in_valid = 1'b0;
        settle();
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_accept got=%0d exp=4", count); end
        cdb_select = 16'h0000;
        settle();
        total++; if (cdb_rrn !== {6'd3, 6'd2}) begin bad++; $display("FAIL full_drain1 got=%h exp=%h", cdb_rrn, {6'd3, 6'd2}); end
        step();
        settle();
        total++; if (cdb_valid !== 2'b11 || cdb_rrn !== {6'd9, 6'd4}) begin bad++; $display("FAIL full_drain2 got=%b/%h exp=11/%h", cdb_valid, cdb_rrn, {6'd9, 6'd4}); end
        step();
        cdb_select = 16'h1111;
        settle();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_empty got=%b exp=1", empty); end
    endtask

    task automatic test_excess();
        do_reset();
        push_one(6'd7);
        cdb_select = 16'h1111;
        settle();
        total++; if (cdb_valid !== 2'b00 || cdb_request !== 1'b1) begin bad++; $display("FAIL nogrant_valid got=%b/req%b exp=00/1", cdb_valid, cdb_request); end
        step();
        total++; if (count !== 3'd1) begin bad++; $display("FAIL nogrant_count got=%0d exp=1", count); end
        cdb_select = {8'h00, 8'h11};
        settle();
        total++; if (cdb_valid !== 2'b10 || cdb_rrn[11:6] !== 6'd7 || cdb_rrn[5:0] !== 6'd0) begin bad++; $display("FAIL bus1_only got=%b/%h exp=10/1c0", cdb_valid, cdb_rrn); end
        cdb_select = 16'h0000;
        settle();
        total++; if (cdb_valid !== 2'b01 || cdb_rrn[5:0] !== 6'd7) begin bad++; $display("FAIL excess_valid got=%b/%0d exp=01/7", cdb_valid, cdb_rrn[5:0]); end
        total++; if (cdb_data[63:32] !== 32'h0 || cdb_rrn[11:6] !== 6'd0) begin bad++; $display("FAIL excess_zero got=%h/%0d exp=0/0", cdb_data[63:32], cdb_rrn[11:6]); end
        step();
        cdb_select = 16'h1111;
        settle();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL excess_count got=%0d exp=0", count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_one(6'd1);
        for (int r = 2; r <= 3; r++) begin
            in_valid = 1'b1; in_rrn = 6'(r); in_data = 32'h100 + 32'(r); cdb_select = {8'h11, 8'h00};
            settle();
            total++; if (cdb_rrn[5:0] !== 6'(r - 1)) begin bad++; $display("FAIL b2b_pop%0d got=%0d exp=%0d", r, cdb_rrn[5:0], r - 1); end
            step();
            total++; if (count !== 3'd1) begin bad++; $display("FAIL b2b_count%0d got=%0d exp=1", r, count); end
        end
        in_valid = 1'b0;
        settle();
        total++; if (cdb_valid !== 2'b01 || cdb_rrn[5:0] !== 6'd3) begin bad++; $display("FAIL b2b_last got=%b/%0d exp=01/3", cdb_valid, cdb_rrn[5:0]); end
        step();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", empty); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int r = 1; r <= 3; r++) push_one(6'(r));
        flush = 1'b1; in_valid = 1'b1; in_rrn = 6'd8; in_data = 32'h108; cdb_select = 16'h0000;
        settle();
        total++; if (cdb_valid !== 2'b00) begin bad++; $display("FAIL flush_valid got=%b exp=00", cdb_valid); end
        total++; if (cdb_request !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_req_rdy got=req%b/rdy%b exp=0/1", cdb_request, in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0; cdb_select = 16'h1111;
        settle();
        total++; if (count !== 3'd0 || empty !== 1'b1) begin bad++; $display("FAIL flush_cleared got=count%0d/empty%b exp=0/1", count, empty); end
        push_one(6'd10);
        cdb_select = 16'h0000;
        settle();
        total++; if (cdb_valid !== 2'b01 || cdb_rrn[5:0] !== 6'd10) begin bad++; $display("FAIL flush_after got=%b/%0d exp=01/10", cdb_valid, cdb_rrn[5:0]); end
        step();
        cdb_select = 16'h1111;
        // reset beats a concurrent push
        push_one(6'd11);
        reset = 1'b1; in_valid = 1'b1; in_rrn = 6'd12;
        step();
        reset = 1'b0; in_valid = 1'b0;
        settle();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_override got=%0d exp=0", count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_full();
        test_excess();
        test_back_to_back();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
